synth_sequencer: RTL and testbench

- Parametrised master sequencer for the TT6581 sample pipeline; supersedes the fixed 3-voice controller.
- On each sample tick it walks NUM_VOICES voices through synth -> envelope multiply -> accumulate, then runs the filter and the volume multiply, and flags the finished sample.
- Adds per-voice enable/skip, a handshake watchdog with abort, overrun detection and a busy flag.
- Sits between the register file and the voice/envelope/multiplier/filter/accumulator datapath.

---
 rtl/synth_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_synth_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_sequencer.sv
// Per-sample voice/filter/volume sequencer: walks enabled voices, then filter and volume, then flags the sample.
// Strobes and muxes are registered one cycle after their state; a ready handshake gates every WAIT state, with a watchdog.
module synth_sequencer #(
  parameter int NUM_VOICES  = 3,
  parameter int IDX_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sample_tick_i,
  input  logic [8*NUM_VOICES-1:0] freq_lo_i,
  input  logic [8*NUM_VOICES-1:0] freq_hi_i,
  input  logic [8*NUM_VOICES-1:0] pw_lo_i,
  input  logic [8*NUM_VOICES-1:0] pw_hi_i,
  input  logic [8*NUM_VOICES-1:0] control_i,
  input  logic [8*NUM_VOICES-1:0] ad_i,
  input  logic [8*NUM_VOICES-1:0] sr_i,
  input  logic [NUM_VOICES-1:0]   voice_en_i,
  input  logic [NUM_VOICES-1:0]   filt_en_i,
  input  logic                    voice_ready_i,
  input  logic                    env_ready_i,
  input  logic                    mult_ready_i,
  input  logic                    filt_ready_i,
  output logic                    voice_start_o,
  output logic                    env_start_o,
  output logic                    mult_start_o,
  output logic                    filt_start_o,
  output logic [IDX_W-1:0]        voice_idx_o,
  output logic [15:0]             voice_freq_o,
  output logic [11:0]             voice_pw_o,
  output logic [3:0]              voice_wave_o,
  output logic                    voice_ring_mod_o,
  output logic                    voice_sync_o,
  output logic                    env_gate_o,
  output logic [3:0]              env_attack_o,
  output logic [3:0]              env_decay_o,
  output logic [3:0]              env_sustain_o,
  output logic [3:0]              env_release_o,
  output logic [1:0]              mult_in_mux_o,
  output logic                    accum_en_o,
  output logic                    accum_rst_o,
  output logic                    accum_mux_o,
  output logic                    audio_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_SYN, S_SYN_WAIT, S_ENV, S_ENV_WAIT,
    S_ACCUM, S_FILT, S_FILT_WAIT, S_VOL, S_VOL_WAIT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cur_q, cur_d;
  logic [NUM_VOICES-1:0]   en_q, en_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    last_voice;
  logic                    wd_expired;
  logic                    timeout_d;
  logic                    voice_start_d, env_start_d, mult_start_d, filt_start_d;
  logic                    accum_en_d, accum_rst_d, accum_mux_d, audio_valid_d;
  logic [1:0]              mux_d;

  assign last_voice = (cur_q == IDX_W'(NUM_VOICES - 1));
  assign wd_expired = (TIMEOUT_CYC != 0) && (wait_cnt_q == CNT_W'(TIMEOUT_CYC));
  assign busy_o     = (state_q != S_IDLE);

  // Voice fields follow cur_q directly so the datapath sees them while the strobe is in flight.
  assign voice_idx_o      = cur_q;
  assign voice_freq_o     = {freq_hi_i[{cur_q, 3'b000} +: 8], freq_lo_i[{cur_q, 3'b000} +: 8]};
  assign voice_pw_o       = {pw_hi_i[{cur_q, 3'b000} +: 4], pw_lo_i[{cur_q, 3'b000} +: 8]};
  assign voice_wave_o     = control_i[{cur_q, 3'b100} +: 4];
  assign voice_ring_mod_o = control_i[{cur_q, 3'b010}];
  assign voice_sync_o     = control_i[{cur_q, 3'b001}];
  assign env_gate_o       = control_i[{cur_q, 3'b000}];
  assign env_attack_o     = ad_i[{cur_q, 3'b100} +: 4];
  assign env_decay_o      = ad_i[{cur_q, 3'b000} +: 4];
  assign env_sustain_o    = sr_i[{cur_q, 3'b100} +: 4];
  assign env_release_o    = sr_i[{cur_q, 3'b000} +: 4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      en_q          <= '0;
      wait_cnt_q    <= '0;
      voice_start_o <= 1'b0;
      env_start_o   <= 1'b0;
      mult_start_o  <= 1'b0;
      filt_start_o  <= 1'b0;
      mult_in_mux_o <= 2'd0;
      accum_en_o    <= 1'b0;
      accum_rst_o   <= 1'b0;
      accum_mux_o   <= 1'b0;
      audio_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      en_q          <= en_d;
      wait_cnt_q    <= wait_cnt_d;
      voice_start_o <= voice_start_d;
      env_start_o   <= env_start_d;
      mult_start_o  <= mult_start_d;
      filt_start_o  <= filt_start_d;
      mult_in_mux_o <= mux_d;
      accum_en_o    <= accum_en_d;
      accum_rst_o   <= accum_rst_d;
      accum_mux_o   <= accum_mux_d;
      audio_valid_o <= audio_valid_d;
      overrun_o     <= sample_tick_i && (state_q != S_IDLE);
      timeout_o     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    en_d          = en_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = 1'b0;
    voice_start_d = 1'b0;
    env_start_d   = 1'b0;
    mult_start_d  = 1'b0;
    filt_start_d  = 1'b0;
    mux_d         = 2'd0;
    accum_en_d    = 1'b0;
    accum_rst_d   = 1'b0;
    accum_mux_d   = 1'b0;
    audio_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        accum_rst_d = 1'b1;
        if (sample_tick_i) begin
          en_d    = voice_en_i;
          cur_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (en_q[cur_q]) state_d = S_SYN;
        else if (last_voice) state_d = S_FILT;
        else cur_d = cur_q + IDX_W'(1);
      end
      S_SYN: begin
        voice_start_d = 1'b1;
        wait_cnt_d    = '0;
        state_d       = S_SYN_WAIT;
      end
      S_SYN_WAIT: begin
        if (voice_ready_i) begin
          state_d = S_ENV;
        end else if (wd_expired) begin
          // Dead voice: drop its contribution and keep the rest of the frame alive.
          timeout_d = 1'b1;
          if (last_voice) state_d = S_FILT;
          else begin
            cur_d   = cur_q + IDX_W'(1);
            state_d = S_SCAN;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ENV: begin
        env_start_d = 1'b1;
        wait_cnt_d  = '0;
        state_d     = S_ENV_WAIT;
      end
      S_ENV_WAIT: begin
        if (env_ready_i) begin
          state_d = S_ACCUM;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          if (last_voice) state_d = S_FILT;
          else begin
            cur_d   = cur_q + IDX_W'(1);
            state_d = S_SCAN;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ACCUM: begin
        accum_en_d  = 1'b1;
        accum_mux_d = filt_en_i[cur_q];
        if (last_voice) state_d = S_FILT;
        else begin
          cur_d   = cur_q + IDX_W'(1);
          state_d = S_SCAN;
        end
      end
      S_FILT: begin
        filt_start_d = 1'b1;
        mux_d        = 2'd1;
        wait_cnt_d   = '0;
        state_d      = S_FILT_WAIT;
      end
      S_FILT_WAIT: begin
        mux_d = 2'd1;
        if (filt_ready_i) state_d = S_VOL;
        else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      S_VOL: begin
        mult_start_d = 1'b1;
        mux_d        = 2'd2;
        wait_cnt_d   = '0;
        state_d      = S_VOL_WAIT;
      end
      S_VOL_WAIT: begin
        mux_d = 2'd2;
        if (mult_ready_i) state_d = S_DONE;
        else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      S_DONE: begin
        audio_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_synth_sequencer.sv
// Directed scoreboard bench: expected voice/accum events are queued per frame and popped as strobes appear.
`timescale 1ns/1ps
module tb_synth_sequencer;
  localparam int NV = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i = 1'b1, sample_tick_i = 1'b0;
  logic [8*NV-1:0] freq_lo_i = 24'h30_20_10, freq_hi_i = 24'hC0_B0_A0;
  logic [8*NV-1:0] pw_lo_i = '0, pw_hi_i = '0, control_i = 24'h41_21_11, ad_i = '0, sr_i = '0;
  logic [NV-1:0] voice_en_i = 3'b111, filt_en_i = 3'b101;
  logic voice_ready_i = 0, env_ready_i = 0, mult_ready_i = 0, filt_ready_i = 0;
  logic voice_start_o, env_start_o, mult_start_o, filt_start_o;
  logic [1:0] voice_idx_o;
  logic [15:0] voice_freq_o;
  logic [11:0] voice_pw_o;
  logic [3:0] voice_wave_o, env_attack_o, env_decay_o, env_sustain_o, env_release_o;
  logic voice_ring_mod_o, voice_sync_o, env_gate_o;
  logic [1:0] mult_in_mux_o;
  logic accum_en_o, accum_rst_o, accum_mux_o, audio_valid_o, busy_o, overrun_o, timeout_o;

  synth_sequencer #(.NUM_VOICES(NV), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_tick_i(sample_tick_i),
    .freq_lo_i(freq_lo_i), .freq_hi_i(freq_hi_i), .pw_lo_i(pw_lo_i), .pw_hi_i(pw_hi_i),
    .control_i(control_i), .ad_i(ad_i), .sr_i(sr_i), .voice_en_i(voice_en_i), .filt_en_i(filt_en_i),
    .voice_ready_i(voice_ready_i), .env_ready_i(env_ready_i), .mult_ready_i(mult_ready_i),
    .filt_ready_i(filt_ready_i), .voice_start_o(voice_start_o), .env_start_o(env_start_o),
    .mult_start_o(mult_start_o), .filt_start_o(filt_start_o), .voice_idx_o(voice_idx_o),
    .voice_freq_o(voice_freq_o), .voice_pw_o(voice_pw_o), .voice_wave_o(voice_wave_o),
    .voice_ring_mod_o(voice_ring_mod_o), .voice_sync_o(voice_sync_o), .env_gate_o(env_gate_o),
    .env_attack_o(env_attack_o), .env_decay_o(env_decay_o), .env_sustain_o(env_sustain_o),
    .env_release_o(env_release_o), .mult_in_mux_o(mult_in_mux_o), .accum_en_o(accum_en_o),
    .accum_rst_o(accum_rst_o), .accum_mux_o(accum_mux_o), .audio_valid_o(audio_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  // Eight-voice instance with immediate ready responses.
  logic tick8 = 1'b0;
  logic [63:0] zero64 = '0;
  logic [7:0] en8 = 8'hFF, fen8 = 8'h00;
  logic v8_rdy = 0, e8_rdy = 0, m8_rdy = 0, f8_rdy = 0;
  logic v8_vs, e8_es, m8_ms, f8_fs;
  logic [2:0] idx8;
  logic [15:0] freq8;
  logic [11:0] pw8;
  logic [3:0] wave8, att8, dec8, sus8, rel8;
  logic ring8, sync8, gate8;
  logic [1:0] mux8;
  logic acc8, arst8, amux8, valid8, busy8, ovr8, to8;

  synth_sequencer #(.NUM_VOICES(8)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .sample_tick_i(tick8),
    .freq_lo_i(zero64), .freq_hi_i(zero64), .pw_lo_i(zero64), .pw_hi_i(zero64),
    .control_i(zero64), .ad_i(zero64), .sr_i(zero64), .voice_en_i(en8), .filt_en_i(fen8),
    .voice_ready_i(v8_rdy), .env_ready_i(e8_rdy), .mult_ready_i(m8_rdy), .filt_ready_i(f8_rdy),
    .voice_start_o(v8_vs), .env_start_o(e8_es), .mult_start_o(m8_ms), .filt_start_o(f8_fs),
    .voice_idx_o(idx8), .voice_freq_o(freq8), .voice_pw_o(pw8), .voice_wave_o(wave8),
    .voice_ring_mod_o(ring8), .voice_sync_o(sync8), .env_gate_o(gate8),
    .env_attack_o(att8), .env_decay_o(dec8), .env_sustain_o(sus8), .env_release_o(rel8),
    .mult_in_mux_o(mux8), .accum_en_o(acc8), .accum_rst_o(arst8), .accum_mux_o(amux8),
    .audio_valid_o(valid8), .busy_o(busy8), .overrun_o(ovr8), .timeout_o(to8)
  );

  always @(negedge clk) begin
    v8_rdy = v8_vs; e8_rdy = e8_es; m8_rdy = m8_ms; f8_rdy = f8_fs;
  end

  // Datapath model: each ready pulses rsp_dly cycles after its start strobe unless withheld.
  int rsp_dly = 2, hold_env_idx = -1;
  bit hold_filt = 0;
  int v_cnt = 0, e_cnt = 0, m_cnt = 0, f_cnt = 0;
  always @(negedge clk) begin
    voice_ready_i = (v_cnt == 1); env_ready_i = (e_cnt == 1);
    mult_ready_i = (m_cnt == 1); filt_ready_i = (f_cnt == 1);
    if (v_cnt > 0) v_cnt--;
    if (e_cnt > 0) e_cnt--;
    if (m_cnt > 0) m_cnt--;
    if (f_cnt > 0) f_cnt--;
    if (voice_start_o === 1'b1) v_cnt = rsp_dly;
    if (env_start_o === 1'b1 && int'(voice_idx_o) != hold_env_idx) e_cnt = rsp_dly;
    if (mult_start_o === 1'b1) m_cnt = rsp_dly;
    if (filt_start_o === 1'b1 && !hold_filt) f_cnt = rsp_dly;
  end

  int n_checks = 0, n_err = 0;
  int exp_vidx[$];
  int exp_amux[$];
  int cyc = 0, t_env = 0, to_gap = 0;
  int c_vs, c_acc, c_filt, c_mult, c_valid, c_to, c_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    int v;
    cyc++;
    if (voice_start_o === 1'b1) begin
      c_vs++;
      chk("vstart_expected", 32'(exp_vidx.size() != 0), 1);
      if (exp_vidx.size() != 0) begin
        v = exp_vidx.pop_front();
        chk("voice_idx", 32'(voice_idx_o), v);
        chk("voice_wave", 32'(voice_wave_o), 1 << v);
        chk("voice_freq", 32'(voice_freq_o), {8'hA0 + 8'(16 * v), 8'h10 + 8'(16 * v)});
      end
    end
    if (accum_en_o === 1'b1) begin
      c_acc++;
      chk("acc_expected", 32'(exp_amux.size() != 0), 1);
      if (exp_amux.size() != 0) chk("accum_mux", 32'(accum_mux_o), exp_amux.pop_front());
    end
    if (env_start_o === 1'b1) begin t_env = cyc; chk("mux_env", 32'(mult_in_mux_o), 0); end
    if (filt_start_o === 1'b1) begin c_filt++; chk("mux_filt", 32'(mult_in_mux_o), 1); end
    if (mult_start_o === 1'b1) begin c_mult++; chk("mux_vol", 32'(mult_in_mux_o), 2); end
    if (audio_valid_o === 1'b1) c_valid++;
    if (timeout_o === 1'b1) begin c_to++; to_gap = cyc - t_env; end
    if (overrun_o === 1'b1) c_ovr++;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_counts();
    c_vs = 0; c_acc = 0; c_filt = 0; c_mult = 0; c_valid = 0; c_to = 0; c_ovr = 0;
  endtask

  task automatic check_counts(input string tag, input int vs, input int acc, input int filt,
                              input int mult, input int valid, input int to, input int ovr);
    chk({tag, "_vstarts"}, c_vs, vs);
    chk({tag, "_accums"}, c_acc, acc);
    chk({tag, "_filt"}, c_filt, filt);
    chk({tag, "_mult"}, c_mult, mult);
    chk({tag, "_valid"}, c_valid, valid);
    chk({tag, "_timeout"}, c_to, to);
    chk({tag, "_overrun"}, c_ovr, ovr);
    chk({tag, "_queues_drained"}, exp_vidx.size() + exp_amux.size(), 0);
    clear_counts();
  endtask

  task automatic push_all(input int env_skip);
    for (int v = 0; v < NV; v++) begin
      exp_vidx.push_back(v);
      if (v != env_skip) exp_amux.push_back(int'(filt_en_i[v]));
    end
  endtask

  task automatic run_frame(input int extra_at);
    bit done;
    done = 0;
    sample_tick_i = 1; step(); sample_tick_i = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (i == extra_at) sample_tick_i = 1;
      step();
      sample_tick_i = 0;
      if (busy_o === 1'b0) done = 1;
    end
    chk("frame_done", 32'(done), 1);
    step();
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({voice_start_o, env_start_o, mult_start_o, filt_start_o, accum_en_o, accum_rst_o,
                accum_mux_o, audio_valid_o, overrun_o, timeout_o, busy_o, mult_in_mux_o, voice_idx_o});
  endfunction

  initial begin
    bit found;
    int n8_vs, n8_valid, max8;
    clear_counts();
    repeat (3) step();
    chk("reset_outputs", out_vec(), 0);
    rst_i = 0;
    step();
    chk("idle_accum_rst", 32'(accum_rst_o), 1);
    chk("idle_busy", 32'(busy_o), 0);

    push_all(-1); run_frame(-1);
    check_counts("all_voices", 3, 3, 1, 1, 1, 0, 0);
    chk("post_frame_accum_rst", 32'(accum_rst_o), 1);

    voice_en_i = 3'b010;
    exp_vidx.push_back(1); exp_amux.push_back(0);
    run_frame(-1);
    check_counts("only_voice1", 1, 1, 1, 1, 1, 0, 0);

    voice_en_i = 3'b000;
    run_frame(-1);
    check_counts("no_voices", 0, 0, 1, 1, 1, 0, 0);

    voice_en_i = 3'b111;
    hold_env_idx = 1;
    push_all(1); run_frame(-1);
    hold_env_idx = -1;
    check_counts("env_timeout", 3, 2, 1, 1, 1, 1, 0);
    // Counter is 0 on the first ENV_WAIT cycle (same cycle env_start_o shows), fires when it equals TO.
    chk("env_timeout_gap", to_gap, TO + 1);

    hold_filt = 1;
    push_all(-1); run_frame(-1);
    hold_filt = 0;
    check_counts("filt_timeout", 3, 3, 1, 0, 0, 1, 0);

    push_all(-1); run_frame(2);
    check_counts("overrun", 3, 3, 1, 1, 1, 0, 1);

    rsp_dly = TO;
    push_all(-1); run_frame(-1);
    check_counts("ready_at_limit", 3, 3, 1, 1, 1, 0, 0);

    rsp_dly = TO + 1;
    for (int v = 0; v < NV; v++) exp_vidx.push_back(v);
    run_frame(-1);
    check_counts("ready_too_late", 3, 0, 1, 0, 0, 4, 0);
    rsp_dly = 2;
    repeat (12) step();
    clear_counts();

    hold_env_idx = 0;
    exp_vidx.push_back(0);
    found = 0;
    sample_tick_i = 1; step(); sample_tick_i = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (env_start_o === 1'b1) found = 1;
    end
    chk("reached_env_wait", 32'(found), 1);
    rst_i = 1; step(); rst_i = 0;
    chk("midframe_reset_outputs", out_vec(), 0);
    hold_env_idx = -1;
    exp_vidx.delete(); exp_amux.delete();
    repeat (12) step();
    clear_counts();
    push_all(-1); run_frame(-1);
    check_counts("after_reset", 3, 3, 1, 1, 1, 0, 0);

    n8_vs = 0; n8_valid = 0; max8 = 0; found = 0;
    tick8 = 1; step(); tick8 = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (v8_vs === 1'b1) begin
        n8_vs++;
        if (int'(idx8) > max8) max8 = int'(idx8);
      end
      if (valid8 === 1'b1) n8_valid++;
      if (busy8 === 1'b0) found = 1;
    end
    chk("nv8_done", 32'(found), 1);
    chk("nv8_vstarts", n8_vs, 8);
    chk("nv8_max_idx", max8, 7);
    chk("nv8_valid", n8_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
